// File: rtl/debounced_counter_with_load.sv
// debounced_counter_with_load
//   Up/down counter with synchronous load, driven straight from raw buttons.
//   Every button is synchronised and debounced. Up and down auto-repeat while
//   held. Load fires once per press. The count either wraps or saturates.
//
// Ports
//   clock       rising-edge clock for all state
//   resetN      asynchronous active-low reset
//   upButton    raw active-high button, count up
//   downButton  raw active-high button, count down
//   loadButton  raw active-high button, load switches
//   switches    load value, sampled when the load request is applied
//   counter     registered count
//   ack         one-cycle pulse, coincident with every applied request
//   atMax       counter is all ones (decoded from the register)
//   atMin       counter is zero (decoded from the register)

// button_debounce: 2-flop synchroniser plus a stable-level debouncer.
//   clock, resetN  clock and async active-low reset
//   raw            asynchronous button input
//   level          debounced level
module button_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 16
) (
  input  logic clock,
  input  logic resetN,
  input  logic raw,
  output logic level
);

  localparam int unsigned CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync1;
  logic          sync2;
  logic [CW-1:0] cnt;

  // The level flips on the edge where the mismatch has lasted DEBOUNCE_CYCLES cycles.
  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      level <= 1'b0;
      cnt   <= '0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
      if (sync2 == level) begin
        cnt <= '0;
      end else if (cnt == LAST) begin
        level <= sync2;
        cnt   <= '0;
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end

endmodule

// press_repeat: turns a debounced level into request pulses with auto-repeat.
//   clock, resetN  clock and async active-low reset
//   level          debounced button level
//   pulse          registered one-cycle request pulse
module press_repeat #(
  parameter int unsigned REPEAT_EN     = 1,
  parameter int unsigned REPEAT_DELAY  = 64,
  parameter int unsigned REPEAT_PERIOD = 8
) (
  input  logic clock,
  input  logic resetN,
  input  logic level,
  output logic pulse
);

  localparam int unsigned TMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int unsigned TW   = $clog2(TMAX + 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    HELD   = 2'd1,
    REPEAT = 2'd2
  } state_t;

  state_t        state;
  logic [TW-1:0] timer;

  // Release always wins over an expiring timer, so no pulse is emitted on release.
  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      state <= IDLE;
      timer <= '0;
      pulse <= 1'b0;
    end else begin
      pulse <= 1'b0;
      case (state)
        IDLE: begin
          if (level) begin
            state <= HELD;
            pulse <= 1'b1;
            timer <= TW'(REPEAT_DELAY);
          end
        end
        HELD: begin
          if (!level) begin
            state <= IDLE;
          end else if (REPEAT_EN != 0) begin
            if (timer == TW'(1)) begin
              state <= REPEAT;
              pulse <= 1'b1;
              timer <= TW'(REPEAT_PERIOD);
            end else begin
              timer <= timer - TW'(1);
            end
          end
        end
        REPEAT: begin
          if (!level) begin
            state <= IDLE;
          end else if (timer == TW'(1)) begin
            pulse <= 1'b1;
            timer <= TW'(REPEAT_PERIOD);
          end else begin
            timer <= timer - TW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

module debounced_counter_with_load #(
  parameter int unsigned WIDTH           = 4,
  parameter int unsigned DEBOUNCE_CYCLES = 16,
  parameter int unsigned REPEAT_EN       = 1,
  parameter int unsigned REPEAT_DELAY    = 64,
  parameter int unsigned REPEAT_PERIOD   = 8,
  parameter int unsigned WRAP            = 1
) (
  input  logic             clock,
  input  logic             resetN,
  input  logic             upButton,
  input  logic             downButton,
  input  logic             loadButton,
  input  logic [WIDTH-1:0] switches,
  output logic [WIDTH-1:0] counter,
  output logic             ack,
  output logic             atMax,
  output logic             atMin
);

  localparam logic [WIDTH-1:0] MAX_VAL = {WIDTH{1'b1}};
  localparam logic [WIDTH-1:0] MIN_VAL = '0;

  logic             up_level;
  logic             down_level;
  logic             load_level;
  logic             up_pulse;
  logic             down_pulse;
  logic             load_prev;
  logic             load_pulse;
  logic [WIDTH-1:0] count_next;
  logic             ack_next;

  button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_up (
    .clock  (clock),
    .resetN (resetN),
    .raw    (upButton),
    .level  (up_level)
  );

  button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_down (
    .clock  (clock),
    .resetN (resetN),
    .raw    (downButton),
    .level  (down_level)
  );

  button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_load (
    .clock  (clock),
    .resetN (resetN),
    .raw    (loadButton),
    .level  (load_level)
  );

  press_repeat #(
    .REPEAT_EN     (REPEAT_EN),
    .REPEAT_DELAY  (REPEAT_DELAY),
    .REPEAT_PERIOD (REPEAT_PERIOD)
  ) u_press_up (
    .clock  (clock),
    .resetN (resetN),
    .level  (up_level),
    .pulse  (up_pulse)
  );

  press_repeat #(
    .REPEAT_EN     (REPEAT_EN),
    .REPEAT_DELAY  (REPEAT_DELAY),
    .REPEAT_PERIOD (REPEAT_PERIOD)
  ) u_press_down (
    .clock  (clock),
    .resetN (resetN),
    .level  (down_level),
    .pulse  (down_pulse)
  );

  // Load: one registered pulse per debounced rise, never repeats.
  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      load_prev  <= 1'b0;
      load_pulse <= 1'b0;
    end else begin
      load_prev  <= load_level;
      load_pulse <= load_level & ~load_prev;
    end
  end

  // Arbitration: load beats up/down; simultaneous up and down cancel.
  always_comb begin
    count_next = counter;
    ack_next   = 1'b0;
    if (load_pulse) begin
      count_next = switches;
      ack_next   = 1'b1;
    end else if (up_pulse && !down_pulse) begin
      ack_next = 1'b1;
      if ((WRAP != 0) || (counter != MAX_VAL)) begin
        count_next = counter + WIDTH'(1);
      end
    end else if (down_pulse && !up_pulse) begin
      ack_next = 1'b1;
      if ((WRAP != 0) || (counter != MIN_VAL)) begin
        count_next = counter - WIDTH'(1);
      end
    end
  end

  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      counter <= '0;
      ack     <= 1'b0;
    end else begin
      counter <= count_next;
      ack     <= ack_next;
    end
  end

  assign atMax = (counter == MAX_VAL);
  assign atMin = (counter == MIN_VAL);

endmodule
